// File: rtl/rv_load_pkg.sv
// rv_load_pkg: RV32I load funct3 codes, load FSM state type and alignment helpers.
package rv_load_pkg;
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;
   function automatic logic f3_illegal(input logic [2:0] f3);
      return f3 == 3'b011 || f3[2:1] == 2'b11;
   endfunction
   function automatic logic is_half(input logic [2:0] f3);
      return f3 == F3_LH || f3 == F3_LHU;
   endfunction
   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
      return (is_half(f3) && lo[0]) || (f3 == F3_LW && lo != 2'b00);
   endfunction
   // Drops the low address bits a halfword or word access cannot use.
   function automatic logic [1:0] align_off(input logic [2:0] f3, input logic [1:0] lo);
      return f3 == F3_LW ? 2'b00 : is_half(f3) ? {lo[1], 1'b0} : lo;
   endfunction
endpackage

// File: rtl/load_extend.sv
// load_extend: selects the byte/halfword lane of a read word and sign- or zero-extends it.
module load_extend
   import rv_load_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2:0]       funct3,
   input  logic [1:0]       addr,
   input  logic [WIDTH-1:0] word,
   output logic [WIDTH-1:0] data
);
   logic [7:0]  b;
   logic [15:0] h;
   always_comb begin
      b = word[{addr, 3'b000} +: 8];
      h = addr[1] ? word[31:16] : word[15:0];
      data = funct3 == F3_LB  ? {{24{b[7]}}, b} :
             funct3 == F3_LBU ? {24'd0, b} :
             funct3 == F3_LH  ? {{16{h[15]}}, h} :
             funct3 == F3_LHU ? {16'd0, h} : word;
   end
endmodule

// File: rtl/load_unit.sv
// load_unit: RV32I load FSM (IDLE/REQ/WAIT/RESP) with lane select and extension.
// Define LOAD_MISALIGN_TRAP_EN to reject misaligned LH/LHU/LW instead of aligning them down.
module load_unit
   import rv_load_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld_req_i,
   input  logic [2:0]       funct3_i,
   input  logic [WIDTH-1:0] addr_i,
   output logic             ld_busy_o,
   output logic             ld_done_o,
   output logic             ld_err_o,
   output logic [WIDTH-1:0] ld_data_o,
   output logic             mem_req_o,
   output logic [WIDTH-1:0] mem_addr_o,
   input  logic             mem_gnt_i,
   input  logic             mem_rvalid_i,
   input  logic [WIDTH-1:0] mem_rdata_i
);
   state_t           state;
   logic [2:0]       f3;
   logic [1:0]       off;
   logic [1:0]       lo;
   logic             bad;
   logic [WIDTH-1:0] ext;
`ifdef LOAD_MISALIGN_TRAP_EN
   assign bad = f3_illegal(funct3_i) || misaligned(funct3_i, addr_i[1:0]);
   assign lo  = addr_i[1:0];
`else
   assign bad = f3_illegal(funct3_i);
   assign lo  = align_off(funct3_i, addr_i[1:0]);
`endif
   load_extend #(.WIDTH(WIDTH)) u_ext (
      .funct3(f3),
      .addr  (off),
      .word  (mem_rdata_i),
      .data  (ext)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         f3         <= 3'd0;
         off        <= 2'd0;
         ld_busy_o  <= 1'b0;
         ld_done_o  <= 1'b0;
         ld_err_o   <= 1'b0;
         ld_data_o  <= '0;
         mem_req_o  <= 1'b0;
         mem_addr_o <= '0;
      end else begin
         case (state)
            S_IDLE: if (ld_req_i) begin
               f3        <= funct3_i;
               off       <= lo;
               ld_busy_o <= 1'b1;
               if (bad) begin
                  state     <= S_RESP;
                  ld_done_o <= 1'b1;
                  ld_err_o  <= 1'b1;
                  ld_data_o <= '0;
               end else begin
                  state      <= S_REQ;
                  mem_req_o  <= 1'b1;
                  mem_addr_o <= {addr_i[WIDTH-1:2], 2'b00};
               end
            end
            S_REQ: if (mem_gnt_i) begin
               state     <= S_WAIT;
               mem_req_o <= 1'b0;
            end
            S_WAIT: if (mem_rvalid_i) begin
               state     <= S_RESP;
               ld_done_o <= 1'b1;
               ld_err_o  <= 1'b0;
               ld_data_o <= ext;
            end
            S_RESP: begin
               state     <= S_IDLE;
               ld_done_o <= 1'b0;
               ld_err_o  <= 1'b0;
               ld_busy_o <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit: directed loads against a scoreboard of expected results.
module tb_load_unit;
   import rv_load_pkg::*;
   logic        clk = 1'b0;
   logic        rst;
   logic        ld_req_i;
   logic [2:0]  funct3_i;
   logic [31:0] addr_i;
   logic        ld_busy_o;
   logic        ld_done_o;
   logic        ld_err_o;
   logic [31:0] ld_data_o;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   typedef struct packed {logic [31:0] data; logic err;} exp_t;
   exp_t sb[$];
   int checks = 0;
   int errors = 0;
   load_unit #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .ld_req_i    (ld_req_i),
      .funct3_i    (funct3_i),
      .addr_i      (addr_i),
      .ld_busy_o   (ld_busy_o),
      .ld_done_o   (ld_done_o),
      .ld_err_o    (ld_err_o),
      .ld_data_o   (ld_data_o),
      .mem_req_o   (mem_req_o),
      .mem_addr_o  (mem_addr_o),
      .mem_gnt_i   (mem_gnt_i),
      .mem_rvalid_i(mem_rvalid_i),
      .mem_rdata_i (mem_rdata_i)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   // Request in cycle 0; grant after gd REQ cycles (with a bogus same-cycle rvalid), rvalid next cycle.
   task automatic run_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd,
                           input int gd, input logic [31:0] ed, input logic ee, input int lat);
      int cyc;
      int wn;
      logic granted;
      logic saw_req;
      exp_t e;
      @(negedge clk);
      ld_req_i = 1'b1;
      funct3_i = f3;
      addr_i   = a;
      sb.push_back({ed, ee});
      @(negedge clk);
      ld_req_i = 1'b0;
      cyc = 1;
      wn = 0;
      granted = 1'b0;
      saw_req = 1'b0;
      while (!ld_done_o && cyc < 40) begin
         mem_gnt_i = 1'b0;
         mem_rvalid_i = 1'b0;
         if (mem_req_o) begin
            saw_req = 1'b1;
            chk("mem_addr", mem_addr_o, {a[31:2], 2'b00});
            if (wn == gd) begin
               mem_gnt_i = 1'b1;
               mem_rvalid_i = 1'b1;
               mem_rdata_i = ~rd;
               granted = 1'b1;
            end
            wn++;
         end else if (granted) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i = rd;
         end
         @(negedge clk);
         cyc++;
      end
      mem_gnt_i = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i = 32'hDEAD_BEEF;
      chk("done", {31'd0, ld_done_o}, 32'd1);
      chk("latency", cyc, lat);
      chk("mem_req_seen", {31'd0, saw_req}, {31'd0, ~ee});
      e = sb.pop_front();
      chk("data", ld_data_o, e.data);
      chk("err", {31'd0, ld_err_o}, {31'd0, e.err});
      chk("busy_resp", {31'd0, ld_busy_o}, 32'd1);
      ld_req_i = 1'b1;
      funct3_i = F3_LW;
      addr_i = 32'h40;
      @(negedge clk);
      ld_req_i = 1'b0;
      chk("done_low", {31'd0, ld_done_o}, 32'd0);
      chk("busy_idle", {31'd0, ld_busy_o}, 32'd0);
      chk("mem_req_idle", {31'd0, mem_req_o}, 32'd0);
      chk("data_hold", ld_data_o, e.data);
   endtask
   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, {31'd0, ld_busy_o}, 32'd0);
      chk({tag, "_done"}, {31'd0, ld_done_o}, 32'd0);
      chk({tag, "_err"}, {31'd0, ld_err_o}, 32'd0);
      chk({tag, "_data"}, ld_data_o, 32'd0);
      chk({tag, "_req"}, {31'd0, mem_req_o}, 32'd0);
      chk({tag, "_addr"}, mem_addr_o, 32'd0);
   endtask
   initial begin
      rst = 1'b1;
      ld_req_i = 1'b0;
      funct3_i = 3'd0;
      addr_i = '0;
      mem_gnt_i = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i = '0;
      @(negedge clk);
      @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;
      run_load(F3_LB,  32'h1003, 32'h80FF_1234, 0, 32'hFFFF_FF80, 1'b0, 3);
      run_load(F3_LHU, 32'h2002, 32'hBEEF_0001, 0, 32'h0000_BEEF, 1'b0, 3);
      run_load(F3_LH,  32'h2002, 32'hBEEF_0001, 1, 32'hFFFF_BEEF, 1'b0, 4);
      run_load(F3_LW,  32'h0010, 32'hCAFE_F00D, 4, 32'hCAFE_F00D, 1'b0, 7);
      run_load(F3_LBU, 32'h1001, 32'h80FF_1234, 0, 32'h0000_0012, 1'b0, 3);
      run_load(F3_LB,  32'h1002, 32'h80FF_1234, 2, 32'hFFFF_FFFF, 1'b0, 5);
      run_load(F3_LH,  32'h0004, 32'h1234_8001, 0, 32'hFFFF_8001, 1'b0, 3);
      run_load(3'b111, 32'h0044, 32'h5555_5555, 0, 32'h0, 1'b1, 1);
      run_load(3'b011, 32'h0048, 32'h5555_5555, 0, 32'h0, 1'b1, 1);
      run_load(3'b110, 32'h004C, 32'h5555_5555, 0, 32'h0, 1'b1, 1);
`ifdef LOAD_MISALIGN_TRAP_EN
      run_load(F3_LW,  32'h0003, 32'h1122_3344, 0, 32'h0, 1'b1, 1);
      run_load(F3_LH,  32'h0001, 32'hBEEF_8001, 0, 32'h0, 1'b1, 1);
      run_load(F3_LHU, 32'h0003, 32'hBEEF_8001, 0, 32'h0, 1'b1, 1);
`else
      run_load(F3_LW,  32'h0003, 32'h1122_3344, 0, 32'h1122_3344, 1'b0, 3);
      run_load(F3_LH,  32'h0001, 32'hBEEF_8001, 0, 32'hFFFF_8001, 1'b0, 3);
      run_load(F3_LHU, 32'h0003, 32'hBEEF_8001, 0, 32'h0000_BEEF, 1'b0, 3);
`endif
      @(negedge clk);
      ld_req_i = 1'b1;
      funct3_i = F3_LW;
      addr_i = 32'h20;
      @(negedge clk);
      ld_req_i = 1'b0;
      mem_gnt_i = 1'b1;
      @(negedge clk);
      mem_gnt_i = 1'b0;
      chk("wait_busy", {31'd0, ld_busy_o}, 32'd1);
      rst = 1'b1;
      #1;
      chk_zero("async_rst");
      @(negedge clk);
      rst = 1'b0;
      mem_rvalid_i = 1'b1;
      mem_rdata_i = 32'h7777_7777;
      @(negedge clk);
      mem_rvalid_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("late_rvalid", {31'd0, ld_done_o | ld_busy_o}, 32'd0);
         @(negedge clk);
      end
      chk_zero("after_rst");
      run_load(F3_LW, 32'h0100, 32'hA5A5_5A5A, 0, 32'hA5A5_5A5A, 1'b0, 3);
      chk("sb_empty", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
